branch_ctrl: RTL and testbench

- Branch-resolution block that drives the program counter's redirect inputs (beq_flag, jmp_flag, Target) from decoded control-flow instructions.
- Holds the equality condition register set by compare instructions and a writable jump-target lookup table.
- Owns a run/halt state machine and raises Done on a halt instruction.
- Sits between the instruction decoder and the program counter.

---
 rtl/branch_ctrl.sv | 111 +++++++++++
 tb/tb_branch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch-resolution block: run/halt FSM, compare-result register and writable
// jump-target table. Define BRANCH_STATS_EN to add the TakenCnt redirect counter.
module branch_ctrl #(
  parameter int A = 10,
  parameter int L = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Valid,
  input  logic         IsCmp,
  input  logic         IsBeq,
  input  logic         IsJmp,
  input  logic         IsHalt,
  input  logic [W-1:0] CmpA,
  input  logic [W-1:0] CmpB,
  input  logic [L-1:0] LutIdx,
  input  logic         LutWe,
  input  logic [L-1:0] LutWaddr,
  input  logic [A-1:0] LutWdata,
  output logic         beq_flag,
  output logic         jmp_flag,
  output logic [A-1:0] Target,
  output logic         Done
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]  TakenCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           eq_q, eq_d;
  logic           done_q, done_d;
  logic [A-1:0]   lut_q [2**L];

  logic           act;
  logic           do_halt, do_jmp, do_beq, do_cmp;

  // Valid qualifies the Is* strobes in RUN only; there is no back-pressure.
  // Only the highest-priority decoded op acts: Halt > Jmp > Beq > Cmp.
  always_comb begin
    act     = (state_q == RUN) && Valid;
    do_halt = act && IsHalt;
    do_jmp  = act && IsJmp && !IsHalt;
    do_beq  = act && IsBeq && !IsJmp && !IsHalt;
    do_cmp  = act && IsCmp && !IsBeq && !IsJmp && !IsHalt;
  end

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (do_halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (do_cmp) eq_d = (CmpA == CmpB);
    done_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  // Table is cleared by reset; software reloads targets afterwards.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2**L; i++) lut_q[i] <= '0;
    end else if (LutWe) begin
      lut_q[LutWaddr] <= LutWdata;
    end
  end

  // beq uses the registered compare result, so a same-cycle compare is not seen.
  assign jmp_flag = do_jmp;
  assign beq_flag = do_beq && eq_q;
  assign Target   = lut_q[LutIdx];
  assign Done     = done_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((beq_flag || jmp_flag) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign TakenCnt = cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed test-plan sequences plus randomized traffic
// compared every cycle against a behavioural model of the branch rules.
module tb_branch_ctrl;
  localparam int A = 10;
  localparam int L = 3;
  localparam int W = 8;

  logic         clk;
  logic         Reset;
  logic         Valid, IsCmp, IsBeq, IsJmp, IsHalt;
  logic [W-1:0] CmpA, CmpB;
  logic [L-1:0] LutIdx;
  logic         LutWe;
  logic [L-1:0] LutWaddr;
  logic [A-1:0] LutWdata;
  logic         beq_flag, jmp_flag, Done;
  logic [A-1:0] Target;
`ifdef BRANCH_STATS_EN
  logic [15:0]  TakenCnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit           m_started;
  bit           m_halted;
  bit           m_eq;
  logic [A-1:0] m_lut [2**L];
  int           m_cnt;

  branch_ctrl #(.A(A), .L(L), .W(W)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Valid    (Valid),
    .IsCmp    (IsCmp),
    .IsBeq    (IsBeq),
    .IsJmp    (IsJmp),
    .IsHalt   (IsHalt),
    .CmpA     (CmpA),
    .CmpB     (CmpB),
    .LutIdx   (LutIdx),
    .LutWe    (LutWe),
    .LutWaddr (LutWaddr),
    .LutWdata (LutWdata),
    .beq_flag (beq_flag),
    .jmp_flag (jmp_flag),
    .Target   (Target),
    .Done     (Done)
`ifdef BRANCH_STATS_EN
    ,
    .TakenCnt (TakenCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    Valid = 0; IsCmp = 0; IsBeq = 0; IsJmp = 0; IsHalt = 0;
    CmpA = '0; CmpB = '0; LutIdx = '0; LutWe = 0; LutWaddr = '0; LutWdata = '0;
  endtask

  task automatic model_reset();
    m_started = 0;
    m_halted  = 0;
    m_eq      = 0;
    m_cnt     = 0;
    for (int i = 0; i < 2**L; i++) m_lut[i] = '0;
  endtask

  // Assert reset wherever we are, check flags drop at once, release on next negedge.
  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check("rst_jmp", jmp_flag, 1'b0);
    check("rst_beq", beq_flag, 1'b0);
    check("rst_done", Done, 1'b0);
`ifdef BRANCH_STATS_EN
    check("rst_cnt", TakenCnt, 16'd0);
`endif
    model_reset();
    @(negedge clk);
    Reset = 1'b1;
  endtask

  // Called at a negedge with inputs set: check outputs, advance one clock.
  task automatic step();
    bit running, ej, eb;
    #1;
    running = m_started && !m_halted;
    ej = running && Valid && IsJmp && !IsHalt;
    eb = running && Valid && IsBeq && !IsJmp && !IsHalt && m_eq;
    check("jmp_flag", jmp_flag, ej);
    check("beq_flag", beq_flag, eb);
    check("target", Target, m_lut[LutIdx]);
    check("done", Done, m_halted);
`ifdef BRANCH_STATS_EN
    check("taken_cnt", TakenCnt, m_cnt);
`endif
    @(posedge clk);
    if (LutWe) m_lut[LutWaddr] = LutWdata;
    if ((ej || eb) && m_cnt < 16'hFFFF) m_cnt++;
    if (!m_started) m_started = 1;
    else if (running && Valid) begin
      if (IsHalt) m_halted = 1;
      else if (IsCmp && !IsJmp && !IsBeq) m_eq = (CmpA == CmpB);
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    Valid    = ($urandom_range(0, 3) != 0);
    IsHalt   = ($urandom_range(0, 63) == 0);
    IsJmp    = ($urandom_range(0, 3) == 0);
    IsBeq    = ($urandom_range(0, 2) == 0);
    IsCmp    = ($urandom_range(0, 1) == 1);
    CmpA     = W'($urandom_range(0, 3));
    CmpB     = W'($urandom_range(0, 3));
    LutIdx   = L'($urandom_range(0, 2**L - 1));
    LutWe    = ($urandom_range(0, 3) == 0);
    LutWaddr = L'($urandom_range(0, 2**L - 1));
    LutWdata = A'($urandom_range(0, 2**A - 1));
  endtask

  initial begin
    Reset = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // IDLE start window ignores the jump, then RUN takes it
    Valid = 1; IsJmp = 1;
    #1 check("tp_idle_jmp", jmp_flag, 1'b0);
    step();
    #1 check("tp_run_jmp", jmp_flag, 1'b1);
    check("tp_run_tgt0", Target, 10'h000);
    step();

    // table write, read-back, read-during-write
    clear_inputs();
    LutWe = 1; LutWaddr = 5; LutWdata = 10'h0A5;
    step();
    clear_inputs();
    Valid = 1; IsJmp = 1; LutIdx = 5;
    #1 check("tp_lut_tgt", Target, 10'h0A5);
    step();
    LutWe = 1; LutWaddr = 5; LutWdata = 10'h111;
    #1 check("tp_rdw_old", Target, 10'h0A5);
    step();
    LutWe = 0;
    #1 check("tp_rdw_new", Target, 10'h111);
    step();

    // compare then branch
    clear_inputs();
    Valid = 1; IsCmp = 1; CmpA = 8'h3C; CmpB = 8'h3C;
    step();
    clear_inputs(); Valid = 1; IsBeq = 1;
    #1 check("tp_beq_eq", beq_flag, 1'b1);
    step();
    clear_inputs(); Valid = 1; IsCmp = 1; CmpA = 8'h3C; CmpB = 8'h3D;
    step();
    clear_inputs(); Valid = 1; IsBeq = 1;
    #1 check("tp_beq_ne", beq_flag, 1'b0);
    step();
    clear_inputs(); Valid = 1; IsCmp = 1; IsBeq = 1; CmpA = 8'h11; CmpB = 8'h11;
    #1 check("tp_cmp_beq_same", beq_flag, 1'b0);
    step();

    // halt beats jump; Done follows and sticks
    clear_inputs(); Valid = 1; IsJmp = 1; IsHalt = 1;
    #1 check("tp_halt_jmp", jmp_flag, 1'b0);
    check("tp_halt_done0", Done, 1'b0);
    step();
    clear_inputs(); Valid = 1; IsJmp = 1;
    #1 check("tp_halted_done", Done, 1'b1);
    check("tp_halted_jmp", jmp_flag, 1'b0);
    step();
    step();

    // reset mid-run while a jump is active
    do_reset();
    clear_inputs(); LutWe = 1; LutWaddr = 5; LutWdata = 10'h0A5;
    step();
    clear_inputs(); Valid = 1; IsJmp = 1; LutIdx = 5;
    #1 check("tp_mid_jmp", jmp_flag, 1'b1);
    do_reset();
    clear_inputs(); LutIdx = 5;
    #1 check("tp_lut_cleared", Target, 10'h000);
    step();

`ifdef BRANCH_STATS_EN
    do_reset();
    clear_inputs();
    step();
    Valid = 1; IsJmp = 1;
    repeat (3) step();
    clear_inputs(); Valid = 1; IsCmp = 1; CmpA = 8'h07; CmpB = 8'h07;
    step();
    clear_inputs(); Valid = 1; IsBeq = 1;
    step();
    clear_inputs(); Valid = 1; IsCmp = 1; CmpA = 8'h07; CmpB = 8'h08;
    step();
    clear_inputs(); Valid = 1; IsBeq = 1;
    step();
    clear_inputs();
    #1 check("tp_cnt4", TakenCnt, 16'd4);
    step();
`endif

    // randomized traffic with periodic resets to leave HALT
    for (int c = 0; c < 600; c++) begin
      if (c % 75 == 74) do_reset();
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
